// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, constants and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic IDLE_BIT = 1'b1;
    localparam int   DATA_W   = 8;

    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_op.sv
// rtl/uart_tx_op.sv - UART transmitter with one-entry holding buffer
// Optional macro UART_TX_STOP2_EN: two stop ticks instead of one.
module uart_tx_op
    import uart_pkg::*;
#(
    parameter logic VERIFY_ON   = 1'b0,
    parameter logic VERIFY_EVEN = 1'b0
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              clk_en_i,
    input  logic              datain_valid_i,
    input  logic [DATA_W-1:0] datain_i,
    output logic              datain_ready_o,
    output logic              uart_tx_o,
    output logic              busy_o
);

    uart_state_e       state_q;
    logic [DATA_W-1:0] buf_q;
    logic              buf_full_q;
    logic [DATA_W-1:0] shift_q;
    logic [2:0]        bit_sel_q;
    logic              parity_q;
    logic              tx_q;
    logic              stop_last;
    logic              load_d;
`ifdef UART_TX_STOP2_EN
    logic              stop_cnt_q;
`endif

    always_comb begin
`ifdef UART_TX_STOP2_EN
        stop_last = stop_cnt_q;
`else
        stop_last = 1'b1;
`endif
        // A buffered byte starts on any tick in IDLE or on the final stop tick.
        load_d = clk_en_i && buf_full_q &&
                 ((state_q == IDLE) || ((state_q == STOP) && stop_last));
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shift_q    <= '0;
            bit_sel_q  <= '0;
            parity_q   <= 1'b0;
            tx_q       <= IDLE_BIT;
`ifdef UART_TX_STOP2_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            if (datain_valid_i && !buf_full_q) begin
                buf_q      <= datain_i;
                buf_full_q <= 1'b1;
            end
            if (load_d) begin
                shift_q    <= buf_q;
                buf_full_q <= 1'b0;
                parity_q   <= parity_bit(buf_q, VERIFY_EVEN);
                tx_q       <= 1'b0;
                state_q    <= START;
            end else if (clk_en_i) begin
                case (state_q)
                    IDLE: tx_q <= IDLE_BIT;
                    START: begin
                        tx_q      <= shift_q[0];
                        bit_sel_q <= '0;
                        state_q   <= DATA;
                    end
                    DATA: begin
                        if (bit_sel_q == 3'd7) begin
`ifdef UART_TX_STOP2_EN
                            stop_cnt_q <= 1'b0;
`endif
                            if (VERIFY_ON) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= IDLE_BIT;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_sel_q <= bit_sel_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[DATA_W-1:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
                    PARITY: begin
`ifdef UART_TX_STOP2_EN
                        stop_cnt_q <= 1'b0;
`endif
                        tx_q    <= IDLE_BIT;
                        state_q <= STOP;
                    end
                    STOP: begin
                        tx_q <= IDLE_BIT;
`ifdef UART_TX_STOP2_EN
                        if (!stop_cnt_q) stop_cnt_q <= 1'b1;
                        else             state_q    <= IDLE;
`else
                        state_q <= IDLE;
`endif
                    end
                    default: begin
                        tx_q    <= IDLE_BIT;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign datain_ready_o = ~buf_full_q;
    assign uart_tx_o      = tx_q;
    assign busy_o         = (state_q != IDLE) || buf_full_q;

endmodule

// File: tb/tb_uart_tx_op.sv
// tb/tb_uart_tx_op.sv - scoreboard bench for uart_tx_op (plain, even and odd parity instances)
module tb_uart_tx_op;

`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clk_en;
    logic       en_high;
    logic       en_prev;
    logic [2:0] valid;
    logic [7:0] data;
    logic       tx0, tx1, tx2, rdy0, rdy1, rdy2, bsy0, bsy1, bsy2;
    logic [2:0] tx, rdy, bsy;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   last_gap = 0;
    logic in_frame = 1'b0;

    assign tx  = {tx2, tx1, tx0};
    assign rdy = {rdy2, rdy1, rdy0};
    assign bsy = {bsy2, bsy1, bsy0};

    uart_tx_op #(.VERIFY_ON(1'b0), .VERIFY_EVEN(1'b0)) dut (
        .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_valid_i(valid[0]),
        .datain_i(data), .datain_ready_o(rdy0), .uart_tx_o(tx0), .busy_o(bsy0));
    uart_tx_op #(.VERIFY_ON(1'b1), .VERIFY_EVEN(1'b1)) dut_even (
        .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_valid_i(valid[1]),
        .datain_i(data), .datain_ready_o(rdy1), .uart_tx_o(tx1), .busy_o(bsy1));
    uart_tx_op #(.VERIFY_ON(1'b1), .VERIFY_EVEN(1'b0)) dut_odd (
        .clk_i(clk), .resetn_i(resetn), .clk_en_i(clk_en), .datain_valid_i(valid[2]),
        .datain_i(data), .datain_ready_o(rdy2), .uart_tx_o(tx2), .busy_o(bsy2));

    always #5 clk = ~clk;

    always @(posedge clk) en_prev <= clk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Tick generator: every 4th clock, or every clock when en_high is set.
    initial begin
        int tcnt = 0;
        clk_en = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            clk_en = en_high || (tcnt % 4 == 0);
        end
    end

    // Monitor: receiver model decoding whichever line starts a frame.
    initial begin
        int         k, n, gap;
        logic [7:0] d;
        logic       p, cur, glitch, stop_ok, aborted;
        exp_t       e;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin gap = 0; continue; end
            if (!en_prev) continue;
            k = -1;
            for (int i = 0; i < 3; i++) if (tx[i] == 1'b0 && k < 0) k = i;
            if (k < 0) begin gap++; continue; end
            last_gap = gap;
            gap = 0;
            in_frame = 1'b1;
            cur = 1'b0; glitch = 1'b0; stop_ok = 1'b1; aborted = 1'b0; d = '0; p = 1'b0;
            n = 8 + ((k > 0) ? 1 : 0) + NSTOP;
            for (int b = 0; b < n && !aborted; ) begin
                @(negedge clk);
                if (!resetn) aborted = 1'b1;
                else if (!en_prev) begin
                    if (tx[k] !== cur) glitch = 1'b1;
                end else begin
                    cur = tx[k];
                    if (b < 8) d[b] = cur;
                    else if (k > 0 && b == 8) p = cur;
                    else if (cur !== 1'b1) stop_ok = 1'b0;
                    b++;
                end
            end
            in_frame = 1'b0;
            if (aborted) continue;
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {24'd0, d}, 32'hFFFF_FFFF);
                continue;
            end
            e = exp_q.pop_front();
            chk("frame_dut", k, e.k);
            chk("frame_data", {24'd0, d}, {24'd0, e.d});
            if (k > 0) chk("frame_parity", {31'd0, p}, {31'd0, e.p});
            chk("frame_stop", {31'd0, stop_ok}, 32'd1);
            chk("frame_glitch", {31'd0, glitch}, 32'd0);
        end
    end

    task automatic send(input int k, input logic [7:0] b, input logic p, output int waited);
        exp_t e;
        data = b;
        valid[k] = 1'b1;
        waited = 0;
        while (!rdy[k] && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!rdy[k]) begin
            chk("accept_timeout", 32'd0, 32'd1);
            valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        e.k = k; e.d = b; e.p = p;
        exp_q.push_back(e);
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_q.size() == 0 && bsy == 3'b000 && !in_frame) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", {31'd0, n >= 3000}, 32'd0);
    endtask

    initial begin
        int w, cnt;
        resetn = 1'b0; valid = '0; data = '0; en_high = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx0}, 32'd1);
        chk("rst_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_busy", {31'd0, bsy0}, 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // 8'hA5, no parity, tick every 4 clocks
        send(0, 8'hA5, 1'b0, w);
        chk("a5_busy", {31'd0, bsy0}, 32'd1);
        wait_done();
        chk("a5_idle_tx", {31'd0, tx0}, 32'd1);
        chk("a5_idle_ready", {31'd0, rdy0}, 32'd1);

        // 8'h07 with even parity (1) and odd parity (0)
        send(1, 8'h07, 1'b1, w);
        wait_done();
        send(2, 8'h07, 1'b0, w);
        wait_done();

        // back-to-back 8'h55 then 8'h0F
        send(0, 8'h55, 1'b0, w);
        chk("q_ready_full", {31'd0, rdy0}, 32'd0);
        send(0, 8'h0F, 1'b0, w);
        chk("q_second_waited", {31'd0, w > 0}, 32'd1);
        wait_done();
        chk("q_gap", last_gap, 32'd0);

        // reset during data bit 3 of 8'hFF
        send(0, 8'hFF, 1'b0, w);
        cnt = 0;
        while (!(en_prev && tx0 == 1'b0) && cnt < 200) begin @(negedge clk); cnt++; end
        chk("ff_start_seen", {31'd0, tx0}, 32'd0);
        cnt = 0;
        while (cnt < 4) begin @(negedge clk); if (en_prev) cnt++; end
        resetn = 1'b0;
        #1;
        chk("mid_rst_tx", {31'd0, tx0}, 32'd1);
        chk("mid_rst_ready", {31'd0, rdy0}, 32'd1);
        chk("mid_rst_busy", {31'd0, bsy0}, 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'h81, 1'b0, w);
        wait_done();

        // clk_en tied high, 8'h3C: busy spans accept cycle plus frame
        en_high = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'h3C, 1'b0, w);
        cnt = 0;
        while (bsy0 && cnt < 100) begin cnt++; @(negedge clk); end
        chk("fast_busy_cycles", cnt, 32'd10 + NSTOP);
        wait_done();
        en_high = 1'b0;
        repeat (4) @(negedge clk);

        // valid pulse while buffer full is dropped
        send(0, 8'h33, 1'b0, w);
        chk("drop_ready_low", {31'd0, rdy0}, 32'd0);
        data = 8'hEE;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        data = '0;
        wait_done();
        repeat (80) @(negedge clk);
        chk("drop_idle_busy", {31'd0, bsy0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
